// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
// Per-channel clock-gating controller. Each of NUM_CH channels has a small FSM
// (ON, IDLE, OFF, WAKE) that produces a registered gate enable. That enable
// drives a latch-based glitch-free gate cell on the ungated source clock.
//
// Optional feature macro: CG_TEST_BYPASS_EN
//   When defined, the block adds a test_en input. test_en=1 forces every gate
//   enable high ahead of the gate latch (scan/DFT). The FSMs, gated and
//   wake_ack keep running normally.
//
// Ports
//   clk        in   1            ungated source clock, rising-edge logic
//   rst        in   1            synchronous active-high reset
//   test_en    in   1            (CG_TEST_BYPASS_EN only) force all clocks on
//   sw_en      in   NUM_CH       software enable, 0 = force gated
//   auto_en    in   NUM_CH       allow automatic idle gating
//   idle_thr   in   IDLE_CNT_W   idle cycles before auto gating (shared)
//   busy       in   NUM_CH       channel activity, 1 = needs clock
//   wake_req   in   NUM_CH       4-phase wake request
//   wake_ack   out  NUM_CH       4-phase wake acknowledge (registered)
//   clk_out    out  NUM_CH       gated clocks
//   gated      out  NUM_CH       1 = channel clock stopped (registered)
//   state_dbg  out  2*NUM_CH     per-channel FSM state, channel i at [2i+1:2i]
//                                (0=ON, 1=IDLE, 2=OFF, 3=WAKE)
//
// Wake handshake (4-phase): the master raises wake_req and holds it. The
// channel raises wake_ack only once it is back in ON with its clock running,
// and keeps it high while wake_req stays high. When wake_req falls, wake_ack
// falls one cycle later. There is no valid/ready stream interface here.
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int IDLE_CNT_W = 8,
    parameter int WAKE_DLY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef CG_TEST_BYPASS_EN
    input  logic                  test_en,
`endif
    input  logic [NUM_CH-1:0]     sw_en,
    input  logic [NUM_CH-1:0]     auto_en,
    input  logic [IDLE_CNT_W-1:0] idle_thr,
    input  logic [NUM_CH-1:0]     busy,
    input  logic [NUM_CH-1:0]     wake_req,
    output logic [NUM_CH-1:0]     wake_ack,
    output logic [NUM_CH-1:0]     clk_out,
    output logic [NUM_CH-1:0]     gated,
    output logic [2*NUM_CH-1:0]   state_dbg
);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    // The wake counter runs 0 .. WAKE_DLY-1.
    localparam int              WAKE_W    = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_DLY - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                state_q, state_d;
        logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
        logic [WAKE_W-1:0]     wake_cnt_q, wake_cnt_d;
        logic                  en_q, gated_q, ack_q, ack_d;
        logic                  gate_en, en_lat;
        logic                  need_clk;

        // Any reason the channel must have (or regain) its clock.
        assign need_clk = busy[i] | wake_req[i] | ~auto_en[i];

        always_comb begin
            state_d    = state_q;
            idle_cnt_d = idle_cnt_q;
            wake_cnt_d = wake_cnt_q;
            if (!sw_en[i]) begin
                state_d = ST_OFF;
            end else begin
                case (state_q)
                    ST_ON: begin
                        if (auto_en[i] && !busy[i] && !wake_req[i]) begin
                            state_d    = ST_IDLE;
                            idle_cnt_d = '0;
                        end
                    end
                    ST_IDLE: begin
                        // busy has priority over an expiring counter.
                        if (need_clk) begin
                            state_d = ST_ON;
                        end else if (idle_cnt_q >= idle_thr) begin
                            // >= also covers idle_thr being lowered while counting.
                            state_d = ST_OFF;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 1'b1;
                        end
                    end
                    ST_OFF: begin
                        if (need_clk) begin
                            state_d    = ST_WAKE;
                            idle_cnt_d = '0;
                            wake_cnt_d = '0;
                        end
                    end
                    ST_WAKE: begin
                        // Runs to completion; only sw_en=0 or rst can abort.
                        if (wake_cnt_q == WAKE_LAST) begin
                            state_d = ST_ON;
                        end else begin
                            wake_cnt_d = wake_cnt_q + 1'b1;
                        end
                    end
                    default: state_d = ST_ON;
                endcase
            end
        end

        // Ack only from a settled ON state. A request seen in IDLE first moves
        // the channel to ON, then acks on the following cycle.
        assign ack_d = (state_q == ST_ON) && (state_d == ST_ON) && wake_req[i];

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_ON;
                idle_cnt_q <= '0;
                wake_cnt_q <= '0;
                en_q       <= 1'b1;
                gated_q    <= 1'b0;
                ack_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                idle_cnt_q <= idle_cnt_d;
                wake_cnt_q <= wake_cnt_d;
                en_q       <= (state_d != ST_OFF);
                gated_q    <= (state_d == ST_OFF);
                ack_q      <= ack_d;
            end
        end

`ifdef CG_TEST_BYPASS_EN
        assign gate_en = en_q | test_en;
`else
        assign gate_en = en_q;
`endif

        // Glitch-free gate: the enable is captured only while clk is low, so
        // it can never change during a high phase of clk_out.
        always_latch begin
            if (!clk) begin
                en_lat <= gate_en;
            end
        end

        assign clk_out[i]           = clk & en_lat;
        assign gated[i]             = gated_q;
        assign wake_ack[i]          = ack_q;
        assign state_dbg[2*i +: 2]  = state_q;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
module tb_clk_gate_ctrl;

  localparam int NUM_CH = 4;
  localparam int HALF   = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #HALF clk = ~clk;

  logic [NUM_CH-1:0] sw_en, auto_en, busy, wake_req;
  logic [7:0]        idle_thr;
  logic [NUM_CH-1:0] wake_ack, clk_out, gated;
  logic [2*NUM_CH-1:0] state_dbg;
`ifdef CG_TEST_BYPASS_EN
  logic test_en;
`endif

  clk_gate_ctrl #(.NUM_CH(NUM_CH), .IDLE_CNT_W(8), .WAKE_DLY(2)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CG_TEST_BYPASS_EN
    .test_en   (test_en),
`endif
    .sw_en     (sw_en),
    .auto_en   (auto_en),
    .idle_thr  (idle_thr),
    .busy      (busy),
    .wake_req  (wake_req),
    .wake_ack  (wake_ack),
    .clk_out   (clk_out),
    .gated     (gated),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // pulse counter sampled inside each high phase of clk
  int rise_cnt [NUM_CH];
  initial for (int c = 0; c < NUM_CH; c++) rise_cnt[c] = 0;
  always @(posedge clk) begin
    #1;
    for (int c = 0; c < NUM_CH; c++) if (clk_out[c] === 1'b1) rise_cnt[c]++;
  end

  // every clk_out pulse must be exactly one clk high phase wide
  for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
    time rise_t = 0;
    always @(posedge clk_out[g]) rise_t = $time;
    always @(negedge clk_out[g]) begin
      if (chk_en) check("pulse_width", 32'($time - rise_t), HALF);
    end
  end

  // stimulus table
  typedef struct {
    logic [3:0] sw;
    logic [3:0] auto_e;
    logic [3:0] bsy;
    logic [3:0] wr;
    logic [7:0] thr;
    logic [3:0] exp_gated;
    logic [3:0] exp_ack;
  } vec_t;

  localparam int NV = 38;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] w, input logic [7:0] t,
                              input logic [3:0] g, input logic [3:0] k);
    vec_t v;
    v.sw = s; v.auto_e = a; v.bsy = b; v.wr = w; v.thr = t; v.exp_gated = g; v.exp_ack = k;
    return v;
  endfunction

  // scoreboard: {gated, ack, clk_out-in-high-phase}
  logic [11:0] exp_q [$];

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [3:0]  prev_gated;
    logic [3:0]  clk_s;
    logic [11:0] e;
    int          snap [NUM_CH];

    // auto gating ch0, idle_thr=5: gated after 7 cycles
    for (int i = 0; i < 6; i++) vt[i] = mk(4'hF, 4'h1, 4'h0, 4'h0, 8'd5, 4'h0, 4'h0);
    vt[6]  = mk(4'hF, 4'h1, 4'h0, 4'h0, 8'd5, 4'h1, 4'h0);
    // ch1 forced off, stays off, then wake handshake
    vt[7]  = mk(4'hD, 4'h3, 4'h0, 4'h0, 8'd5, 4'h3, 4'h0);
    vt[8]  = mk(4'hF, 4'h3, 4'h0, 4'h0, 8'd5, 4'h3, 4'h0);
    vt[9]  = mk(4'hF, 4'h3, 4'h0, 4'h2, 8'd5, 4'h1, 4'h0);
    vt[10] = mk(4'hF, 4'h3, 4'h0, 4'h2, 8'd5, 4'h1, 4'h0);
    vt[11] = mk(4'hF, 4'h3, 4'h0, 4'h2, 8'd5, 4'h1, 4'h0);
    vt[12] = mk(4'hF, 4'h3, 4'h0, 4'h2, 8'd5, 4'h1, 4'h2);
    vt[13] = mk(4'hF, 4'h3, 4'h0, 4'h2, 8'd5, 4'h1, 4'h2);
    vt[14] = mk(4'hF, 4'h1, 4'h0, 4'h0, 8'd5, 4'h1, 4'h0);
    // busy race on ch2, idle_thr=3
    for (int i = 15; i < 19; i++) vt[i] = mk(4'hF, 4'h5, 4'h0, 4'h0, 8'd3, 4'h1, 4'h0);
    vt[19] = mk(4'hF, 4'h5, 4'h4, 4'h0, 8'd3, 4'h1, 4'h0);
    vt[20] = mk(4'hF, 4'h1, 4'h0, 4'h0, 8'd3, 4'h1, 4'h0);
    // idle_thr=0 on ch3: gate one cycle after entering IDLE
    vt[21] = mk(4'hF, 4'h9, 4'h0, 4'h0, 8'd0, 4'h1, 4'h0);
    vt[22] = mk(4'hF, 4'h9, 4'h0, 4'h0, 8'd0, 4'h9, 4'h0);
    // ch3 woken by busy, sw disable during WAKE, held off, re-woken
    vt[23] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h1, 4'h0);
    vt[24] = mk(4'h7, 4'h9, 4'h8, 4'h0, 8'd0, 4'h9, 4'h0);
    vt[25] = mk(4'h7, 4'h9, 4'h8, 4'h0, 8'd0, 4'h9, 4'h0);
    vt[26] = mk(4'h7, 4'h9, 4'h8, 4'h0, 8'd0, 4'h9, 4'h0);
    vt[27] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h1, 4'h0);
    vt[28] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h1, 4'h0);
    vt[29] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h1, 4'h0);
    // ch0 woken, wake_req dropped during WAKE: no ack
    vt[30] = mk(4'hF, 4'h9, 4'h8, 4'h1, 8'd0, 4'h0, 4'h0);
    vt[31] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h0, 4'h0);
    vt[32] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h0, 4'h0);
    vt[33] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h0, 4'h0);
    // wake_req in IDLE: back to ON first, ack one cycle later
    vt[34] = mk(4'hF, 4'h9, 4'h8, 4'h1, 8'd0, 4'h0, 4'h0);
    vt[35] = mk(4'hF, 4'h9, 4'h8, 4'h1, 8'd0, 4'h0, 4'h1);
    vt[36] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h0, 4'h0);
    vt[37] = mk(4'hF, 4'h9, 4'h8, 4'h0, 8'd0, 4'h1, 4'h0);

    // reset
    rst = 1'b1; sw_en = 4'hF; auto_en = 4'h0; busy = 4'h0; wake_req = 4'h0; idle_thr = 8'd5;
`ifdef CG_TEST_BYPASS_EN
    test_en = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_gated", 32'(gated), 32'h0);
    check("rst_ack", 32'(wake_ack), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) snap[c] = rise_cnt[c];
    repeat (3) @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) check("rst_clk_pulses", 32'(rise_cnt[c] - snap[c]), 32'd3);
    chk_en = 1'b1;

    // table-driven vectors
    prev_gated = 4'h0;
    for (int i = 0; i < NV; i++) begin
      sw_en = vt[i].sw; auto_en = vt[i].auto_e; busy = vt[i].bsy;
      wake_req = vt[i].wr; idle_thr = vt[i].thr;
      exp_q.push_back({vt[i].exp_gated, vt[i].exp_ack, ~prev_gated});
      prev_gated = vt[i].exp_gated;
      @(posedge clk);
      #1 clk_s = clk_out;
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d_gated", i), 32'(gated), 32'(e[11:8]));
      check($sformatf("v%0d_ack", i), 32'(wake_ack), 32'(e[7:4]));
      check($sformatf("v%0d_clk_out", i), 32'(clk_s), 32'(e[3:0]));
    end

    // reset in the middle of WAKE (ch0 is OFF here)
    auto_en = 4'h1; busy = 4'h0; wake_req = 4'h1;
    @(negedge clk);
    check("mid_wake_state", 32'(state_dbg[1:0]), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(state_dbg), 32'h0);
    check("mid_rst_gated", 32'(gated), 32'h0);
    check("mid_rst_ack", 32'(wake_ack), 32'h0);
    rst = 1'b0; wake_req = 4'h0; auto_en = 4'h0;
    @(posedge clk);
    #1 check("mid_rst_clk_out", 32'(clk_out), 32'hF);
    @(negedge clk);

`ifdef CG_TEST_BYPASS_EN
    // bypass: all channels OFF, test_en forces clocks on, status unchanged
    sw_en = 4'h0;
    repeat (2) @(negedge clk);
    check("byp_gated_off", 32'(gated), 32'hF);
    test_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check("byp_clk_out", 32'(clk_out), 32'hF);
      @(negedge clk);
      check("byp_gated", 32'(gated), 32'hF);
    end
    test_en = 1'b0;
    @(posedge clk);
    #1 check("byp_off_clk_out", 32'(clk_out), 32'h0);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
